// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage core: stall encoding, exception redirect FSM,
// consecutive-stall timeout flag. Optional stall-cycle counter behind macro STALL_PERF_EN.
module pipe_stall_ctrl #(
  parameter logic [31:0] EXC_BASE  = 32'h0000_0020,
  parameter int          TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic        exc_eret,
  input  logic [31:0] epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  state_t               state_reg, state_next;
  logic                 flush_reg, flush_next;
  logic [31:0]          new_pc_reg, new_pc_next;
  logic [TIMEOUT_W-1:0] cnt_reg, cnt_next;
  logic                 timeout_reg, timeout_next;
  logic [3:0]           req_vec;
  logic [5:0]           stall_enc;
  logic                 any_req;
  logic                 in_flush;

  assign req_vec  = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if};
  assign any_req  = |req_vec;
  assign in_flush = (state_reg == FLUSH);

  // Stage bit gi is held when any requester at or beyond stage gi-1 asks; OR of the
  // per-requester thermometer codes is the same as picking the highest requester.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_stall
      if (gi == 5) begin : g_wb
        assign stall_enc[gi] = 1'b0;
      end else if (gi < 2) begin : g_front
        assign stall_enc[gi] = any_req;
      end else begin : g_back
        assign stall_enc[gi] = |req_vec[3:gi-1];
      end
    end
  endgenerate

  assign stall = (rst && !in_flush) ? stall_enc : 6'b000000;

  always_comb begin
    state_next  = state_reg;
    new_pc_next = new_pc_reg;
    case (state_reg)
      IDLE: begin
        // A MEM-stage wait keeps the excepting instruction in place, so defer the take.
        if (exc_valid && !stallreq_mem) begin
          state_next  = FLUSH;
          new_pc_next = exc_eret ? epc : EXC_BASE;
        end
      end
      FLUSH:   state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    flush_next = (state_next == FLUSH);
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (in_flush || !any_req) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + TIMEOUT_W'(1);
    end
    timeout_next = timeout_reg | (cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      flush_reg   <= 1'b0;
      new_pc_reg  <= 32'h0000_0000;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      flush_reg   <= flush_next;
      new_pc_reg  <= new_pc_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign flush         = flush_reg;
  assign new_pc        = new_pc_reg;
  assign stall_timeout = timeout_reg;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_reg <= 32'h0000_0000;
    end else if (stall[0]) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

  localparam int TW   = 4;
  localparam int MAXC = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_if, s_id, s_ex, s_mem;
  logic        exc_v, exc_e;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.EXC_BASE(32'h0000_0020), .TIMEOUT_W(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (s_if),
    .stallreq_id   (s_id),
    .stallreq_ex   (s_ex),
    .stallreq_mem  (s_mem),
    .exc_valid     (exc_v),
    .exc_eret      (exc_e),
    .epc           (epc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout)
`ifdef STALL_PERF_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = normal, 1 = redirect cycle, 2 = recovery cycle
  int          m_phase;
  logic [31:0] m_pc;
  int          m_run;
  bit          m_to;
  logic [31:0] m_perf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 32'h0;
    m_run   = 0;
    m_to    = 0;
    m_perf  = 32'h0;
  endtask

  function automatic logic [5:0] model_stall();
    int lvl;
    lvl = s_mem ? 4 : s_ex ? 3 : s_id ? 2 : s_if ? 1 : 0;
    if (m_phase == 1 || lvl == 0) return 6'b000000;
    return 6'((1 << (lvl + 1)) - 1);
  endfunction

  task automatic drive(input bit i, input bit d, input bit e, input bit m,
                       input bit v, input bit r, input logic [31:0] pc);
    s_if = i; s_id = d; s_ex = e; s_mem = m; exc_v = v; exc_e = r; epc = pc;
  endtask

  task automatic check_regs();
    chk("flush", {31'b0, flush}, {31'b0, m_phase == 1});
    chk("new_pc", new_pc, m_pc);
    chk("timeout", {31'b0, stall_timeout}, {31'b0, m_to});
`ifdef STALL_PERF_EN
    chk("stall_cycles", stall_cycles, m_perf);
`endif
  endtask

  // One clock: check combinational stall mid-cycle, advance the model at the edge,
  // then check the registered outputs just after it.
  task automatic cycle();
    logic [5:0] es;
    @(negedge clk);
    es = model_stall();
    chk("stall", {26'b0, stall}, {26'b0, es});
    @(posedge clk);
    if (m_phase == 1 || !(s_if | s_id | s_ex | s_mem)) m_run = 0;
    else if (m_run < MAXC) m_run++;
    if (m_run == MAXC) m_to = 1;
    if (es[0]) m_perf = m_perf + 32'd1;
    case (m_phase)
      0: if (exc_v && !s_mem) begin
           m_phase = 1;
           m_pc = exc_e ? epc : 32'h0000_0020;
         end
      1: m_phase = 2;
      default: m_phase = 0;
    endcase
    #2;
    check_regs();
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    model_reset();
    #2;
    chk("reset_stall", {26'b0, stall}, 32'h0);
    chk("reset_flush", {31'b0, flush}, 32'h0);
    chk("reset_new_pc", new_pc, 32'h0);
    chk("reset_timeout", {31'b0, stall_timeout}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // Priority encode
    drive(1, 1, 1, 1, 0, 0, 32'h0);
    #1 chk("prio_all", {26'b0, stall}, 32'h1F);
    cycle();
    drive(1, 1, 1, 0, 0, 0, 32'h0);
    #1 chk("prio_no_mem", {26'b0, stall}, 32'h0F);
    cycle();
    drive(1, 1, 0, 0, 0, 0, 32'h0);
    #1 chk("prio_no_ex", {26'b0, stall}, 32'h07);
    cycle();
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    #1 chk("prio_if", {26'b0, stall}, 32'h03);
    cycle();

    // Exception, with re-pulses during FLUSH and RECOVER ignored
    drive(0, 0, 0, 0, 1, 0, 32'h0);
    cycle();
    chk("exc_flush", {31'b0, flush}, 32'h1);
    chk("exc_new_pc", new_pc, 32'h20);
    drive(0, 0, 1, 0, 1, 0, 32'h0);
    #1 chk("exc_stall_zero", {26'b0, stall}, 32'h0);
    cycle();
    chk("exc_flush_drop", {31'b0, flush}, 32'h0);
    drive(0, 0, 0, 0, 1, 0, 32'h0);
    cycle();
    chk("exc_recover_ignored", {31'b0, flush}, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    cycle();

    // ERET held back by MEM wait
    drive(0, 0, 0, 1, 1, 1, 32'h0000_1234);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("eret_held", {31'b0, flush}, 32'h0);
    end
    drive(0, 0, 0, 0, 1, 1, 32'h0000_1234);
    cycle();
    chk("eret_flush", {31'b0, flush}, 32'h1);
    chk("eret_new_pc", new_pc, 32'h0000_1234);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    cycle();
    cycle();

    // Timeout after 2**TW-1 consecutive stalled cycles, sticky after release
    drive(0, 0, 1, 0, 0, 0, 32'h0);
    for (int k = 0; k < MAXC - 1; k++) cycle();
    chk("timeout_before", {31'b0, stall_timeout}, 32'h0);
    cycle();
    chk("timeout_hit", {31'b0, stall_timeout}, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    cycle();
    chk("timeout_sticky", {31'b0, stall_timeout}, 32'h1);

    // Asynchronous reset while in FLUSH
    drive(0, 0, 1, 0, 1, 0, 32'h0);
    cycle();
    chk("pre_rst_flush", {31'b0, flush}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("arst_flush", {31'b0, flush}, 32'h0);
    chk("arst_stall", {26'b0, stall}, 32'h0);
    chk("arst_timeout", {31'b0, stall_timeout}, 32'h0);
    chk("arst_new_pc", new_pc, 32'h0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cycle();

`ifdef STALL_PERF_EN
    drive(0, 1, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 10; k++) cycle();
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    cycle();
    chk("perf_ten", stall_cycles, 32'd10);
`endif

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
            ($urandom % 4) == 0, ($urandom % 5) == 0, $urandom % 2, $urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
